// File: rtl/score_recorder_if.sv
// rtl/score_recorder_if.sv - submit/result bus between a game controller and score_recorder
interface score_recorder_if;
    logic       submit;
    logic       isGuest;
    logic [2:0] intIDin;
    logic [3:0] scoreOnes;
    logic [3:0] scoreTens;
    logic       busy;
    logic       done;
    logic       newBest;
    logic       newTop;
    logic       reject;
    logic       topValid;
    logic [4:0] topIntID;
    logic [3:0] topScoreOnes;
    logic [3:0] topScoreTens;

    modport master (
        output submit, isGuest, intIDin, scoreOnes, scoreTens,
        input  busy, done, newBest, newTop, reject,
        input  topValid, topIntID, topScoreOnes, topScoreTens
    );

    modport slave (
        input  submit, isGuest, intIDin, scoreOnes, scoreTens,
        output busy, done, newBest, newTop, reject,
        output topValid, topIntID, topScoreOnes, topScoreTens
    );
endinterface

// File: rtl/score_recorder.sv
// rtl/score_recorder.sv - per-user personal-best table plus overall top score and holder
// Optional clr port and table clear enabled by SCORE_CLEAR_EN.
module score_recorder #(
    parameter int NUM_USERS = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef SCORE_CLEAR_EN
    input  logic clr,
`endif
    score_recorder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, CMP, WRITE, DONE} state_t;

    state_t     state;
    logic       guest_q;
    logic [2:0] id_q;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic [7:0] hold_q;
    logic       best_q;
    logic       top_q;
    logic       rej_q;
    logic [7:0] table_q [NUM_USERS];
    logic [7:0] top_score_q;
    logic [2:0] top_id_q;
    logic       top_valid_q;
    logic       busy_q;
    logic       done_q;
    logic       new_best_q;
    logic       new_top_q;
    logic       reject_q;
    logic [7:0] score;

    // Valid BCD digits concatenated order correctly as an unsigned byte.
    assign score = {tens_q, ones_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            guest_q     <= 1'b0;
            id_q        <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            hold_q      <= '0;
            best_q      <= 1'b0;
            top_q       <= 1'b0;
            rej_q       <= 1'b0;
            for (int i = 0; i < NUM_USERS; i++) table_q[i] <= '0;
            top_score_q <= '0;
            top_id_q    <= '0;
            top_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            new_best_q  <= 1'b0;
            new_top_q   <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
`ifdef SCORE_CLEAR_EN
                    if (clr) begin
                        for (int i = 0; i < NUM_USERS; i++) table_q[i] <= '0;
                        top_score_q <= '0;
                        top_id_q    <= '0;
                        top_valid_q <= 1'b0;
                    end else
`endif
                    if (bus.submit) begin
                        guest_q <= bus.isGuest;
                        id_q    <= bus.intIDin;
                        tens_q  <= bus.scoreTens;
                        ones_q  <= bus.scoreOnes;
                        busy_q  <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    hold_q <= table_q[id_q];
                    state  <= CMP;
                end
                CMP: begin
                    // Strict greater-than: ties never displace the earlier holder.
                    rej_q  <= guest_q || (ones_q > 4'd9) || (tens_q > 4'd9);
                    best_q <= !(guest_q || (ones_q > 4'd9) || (tens_q > 4'd9)) && (score > hold_q);
                    top_q  <= !(guest_q || (ones_q > 4'd9) || (tens_q > 4'd9)) && (score > hold_q)
                              && (!top_valid_q || (score > top_score_q));
                    state  <= WRITE;
                end
                WRITE: begin
                    if (best_q) table_q[id_q] <= score;
                    if (top_q) begin
                        top_score_q <= score;
                        top_id_q    <= id_q;
                        top_valid_q <= 1'b1;
                    end
                    done_q     <= 1'b1;
                    new_best_q <= best_q;
                    new_top_q  <= top_q;
                    reject_q   <= rej_q;
                    state      <= DONE;
                end
                DONE: begin
                    done_q     <= 1'b0;
                    new_best_q <= 1'b0;
                    new_top_q  <= 1'b0;
                    reject_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.newBest      = new_best_q;
    assign bus.newTop       = new_top_q;
    assign bus.reject       = reject_q;
    assign bus.topValid     = top_valid_q;
    assign bus.topIntID     = {2'b00, top_id_q};
    assign bus.topScoreTens = top_score_q[7:4];
    assign bus.topScoreOnes = top_score_q[3:0];
endmodule

// File: tb/tb_score_recorder.sv
// tb/tb_score_recorder.sv - scoreboard bench for score_recorder
module tb_score_recorder;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SCORE_CLEAR_EN
    logic clr = 1'b0;
`endif
    int n_cmp = 0;
    int n_mis = 0;

    score_recorder_if bus();

    score_recorder dut (
        .clk (clk),
        .rst (rst),
`ifdef SCORE_CLEAR_EN
        .clr (clr),
`endif
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       best;
        logic       top;
        logic       rej;
        logic       tv;
        logic [2:0] tid;
        logic [7:0] ts;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_tbl [8];
    logic [7:0] ref_ts;
    logic [2:0] ref_tid;
    logic       ref_tv;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_tbl[i] = 8'h00;
        ref_ts  = 8'h00;
        ref_tid = 3'd0;
        ref_tv  = 1'b0;
    endtask

    task automatic check_top(input string tag);
        check_eq({tag, ".topValid"}, 32'(bus.topValid), 32'(ref_tv));
        check_eq({tag, ".topIntID"}, 32'(bus.topIntID), {27'd0, 2'b00, ref_tid});
        check_eq({tag, ".topTens"}, 32'(bus.topScoreTens), 32'(ref_ts[7:4]));
        check_eq({tag, ".topOnes"}, 32'(bus.topScoreOnes), 32'(ref_ts[3:0]));
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the first IDLE cycle after DONE.
    task automatic do_submit(input string tag, input logic g, input logic [2:0] id,
                             input logic [3:0] t, input logic [3:0] o, input logic poke);
        exp_t e;
        exp_t got;
        logic [7:0] s;
        int cyc;
        int extra;
        s     = {t, o};
        e.rej = g || (t > 4'd9) || (o > 4'd9);
        e.best = !e.rej && (s > ref_tbl[id]);
        e.top  = e.best && (!ref_tv || s > ref_ts);
        if (e.best) ref_tbl[id] = s;
        if (e.top) begin
            ref_ts  = s;
            ref_tid = id;
            ref_tv  = 1'b1;
        end
        e.tv  = ref_tv;
        e.tid = ref_tid;
        e.ts  = ref_ts;
        sb.push_back(e);

        bus.submit = 1'b1; bus.isGuest = g; bus.intIDin = id;
        bus.scoreTens = t; bus.scoreOnes = o;
        @(negedge clk);
        bus.submit = 1'b0;
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
        cyc = 1;
        while (!bus.done && cyc < 12) begin
            if (poke && cyc == 2) begin
                bus.submit = 1'b1; bus.isGuest = 1'b0; bus.intIDin = id;
                bus.scoreTens = 4'd9; bus.scoreOnes = 4'd9;
            end
            @(negedge clk);
            bus.submit = 1'b0;
            cyc++;
        end
        check_eq({tag, ".latency"}, 32'(cyc), 32'd4);
        if (bus.done) begin
            got = sb.pop_front();
            check_eq({tag, ".newBest"}, 32'(bus.newBest), 32'(got.best));
            check_eq({tag, ".newTop"}, 32'(bus.newTop), 32'(got.top));
            check_eq({tag, ".reject"}, 32'(bus.reject), 32'(got.rej));
            check_eq({tag, ".topValid"}, 32'(bus.topValid), 32'(got.tv));
            check_eq({tag, ".topIntID"}, 32'(bus.topIntID), {27'd0, 2'b00, got.tid});
            check_eq({tag, ".topScore"}, {24'd0, bus.topScoreTens, bus.topScoreOnes}, {24'd0, got.ts});
        end else begin
            void'(sb.pop_front());
        end
        @(negedge clk);
        check_eq({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ".idle_flags"}, {29'd0, bus.done, bus.newBest, bus.newTop}, 32'd0);
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            check_eq({tag, ".no_queued_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int dn;
        bus.submit = 1'b0; bus.isGuest = 1'b0; bus.intIDin = '0;
        bus.scoreTens = '0; bus.scoreOnes = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("reset.busy", 32'(bus.busy), 32'd0);
        check_eq("reset.flags", {28'd0, bus.done, bus.newBest, bus.newTop, bus.reject}, 32'd0);
        check_top("reset");
        @(negedge clk);

        do_submit("id3_42",    1'b0, 3'd3, 4'd4, 4'd2, 1'b0);
        do_submit("id5_42tie", 1'b0, 3'd5, 4'd4, 4'd2, 1'b0);
        do_submit("id5_57",    1'b0, 3'd5, 4'd5, 4'd7, 1'b0);
        do_submit("id5_30",    1'b0, 3'd5, 4'd3, 4'd0, 1'b0);
        do_submit("guest99",   1'b1, 3'd2, 4'd9, 4'd9, 1'b0);
        do_submit("ones12",    1'b0, 3'd2, 4'd1, 4'd12, 1'b0);
        do_submit("tens10",    1'b0, 3'd1, 4'd10, 4'd5, 1'b0);
        do_submit("id4_00",    1'b0, 3'd4, 4'd0, 4'd0, 1'b0);
        do_submit("id5_60",    1'b0, 3'd5, 4'd6, 4'd0, 1'b0);
        do_submit("id6_poke",  1'b0, 3'd6, 4'd2, 4'd0, 1'b1);
        do_submit("id6_20tie", 1'b0, 3'd6, 4'd2, 4'd0, 1'b0);

        // Reset while the request sits in READ must drop it without a done pulse.
        bus.submit = 1'b1; bus.isGuest = 1'b0; bus.intIDin = 3'd7;
        bus.scoreTens = 4'd8; bus.scoreOnes = 4'd8;
        @(negedge clk);
        bus.submit = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        check_eq("midrst.busy", 32'(bus.busy), 32'd0);
        check_eq("midrst.flags", {28'd0, bus.done, bus.newBest, bus.newTop, bus.reject}, 32'd0);
        check_top("midrst");
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check_eq("midrst.no_done", 32'(dn), 32'd0);
        do_submit("post_rst_id7_10", 1'b0, 3'd7, 4'd1, 4'd0, 1'b0);

`ifdef SCORE_CLEAR_EN
        do_submit("pre_clr_id3_50", 1'b0, 3'd3, 4'd5, 4'd0, 1'b0);
        clr = 1'b1;
        bus.submit = 1'b1; bus.intIDin = 3'd2; bus.scoreTens = 4'd9; bus.scoreOnes = 4'd9;
        @(negedge clk);
        clr = 1'b0;
        bus.submit = 1'b0;
        model_reset();
        check_eq("clr.busy", 32'(bus.busy), 32'd0);
        check_top("clr");
        @(negedge clk);
        check_eq("clr.no_done", 32'(bus.done), 32'd0);
        do_submit("post_clr_id3_10", 1'b0, 3'd3, 4'd1, 4'd0, 1'b0);
`endif

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
